oled_bus_arbiter: RTL and testbench

- Shared-bus sequencer for the OLED I2C lines. Grants one of NUM_CH client engines (init, write, scroll, etc.) exclusive ownership of OLED_SCL/OLED_SDA.
- Uses a start/done handshake, a registered bus mux, an enforced bus-free gap between owners and a per-grant watchdog.
- Sits between the OLED top-level control and the pins. The idle bus is driven high/released, never undefined.

---
 rtl/oled_bus_arbiter_if.sv | 50 +++++
 rtl/oled_bus_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_oled_bus_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// oled_bus_arbiter_if
//
// Purpose:
//   Bundles the per-channel handshake and bus-drive signals exchanged between
//   the OLED client engines (init, write, scroll, ...) and the shared-bus
//   arbiter. One bit per channel on every vector.
//
// Signals (all NUM_CH wide):
//   req        - client bus request, level, held until done
//   done       - client transfer-complete pulse (1 cycle)
//   grant      - one-hot start/ownership from the arbiter (registered)
//   ch_scl     - client SCL value
//   ch_sda_out - client SDA data
//   ch_sda_oe  - client SDA drive enable (1 = drive ch_sda_out)
//
// Modports:
//   master - client side (drives requests and bus values, receives grant)
//   slave  - arbiter side (receives requests and bus values, drives grant)
// -----------------------------------------------------------------------------
interface oled_bus_arbiter_if #(
    parameter int NUM_CH = 2
);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] ch_scl;
    logic [NUM_CH-1:0] ch_sda_out;
    logic [NUM_CH-1:0] ch_sda_oe;

    modport master (
        output req,
        output done,
        output ch_scl,
        output ch_sda_out,
        output ch_sda_oe,
        input  grant
    );

    modport slave (
        input  req,
        input  done,
        input  ch_scl,
        input  ch_sda_out,
        input  ch_sda_oe,
        output grant
    );

endinterface

// File: rtl/oled_bus_arbiter.sv
// -----------------------------------------------------------------------------
// oled_bus_arbiter
//
// Purpose:
//   Shared-bus sequencer for the OLED I2C lines. Grants one of NUM_CH client
//   engines exclusive ownership of OLED_SCL/OLED_SDA using a start/done
//   handshake, drives the pins through a registered mux, inserts a bus-free
//   gap after every owner and forcibly releases a channel that holds the bus
//   for too long. The idle bus is SCL high with SDA released.
//
// Parameters:
//   NUM_CH         - number of client channels (1..8), index 0 highest priority
//   GAP_CYCLES     - idle cycles inserted after every grant (0 = no gap)
//   TIMEOUT_CYCLES - maximum cycles a channel may own the bus
//   TO_W           - watchdog width, 2**TO_W must exceed TIMEOUT_CYCLES
//
// Ports:
//   clk_i         - system clock
//   rst_n_i       - asynchronous active-low reset
//   bus_io        - client handshake/bus interface (slave modport)
//   OLED_SCL_o    - bus clock (registered)
//   OLED_SDA_io   - bus data, tri-stated when not driven
//   sda_in_o      - OLED_SDA through a 2-flop synchroniser (for ACK reads)
//   busy_o        - high while a channel owns the bus or the gap is running
//   timeout_err_o - sticky watchdog-expiry flag, cleared only by reset
//   err_ch_o      - channel index of the most recent watchdog expiry
//
// Configuration:
//   OLED_ARB_ROUND_ROBIN_EN - when defined, channel selection is round-robin
//                             starting after the last granted channel; when
//                             undefined, the lowest requesting index wins.
// -----------------------------------------------------------------------------
module oled_bus_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    oled_bus_arbiter_if.slave        bus_io,
    output logic                     OLED_SCL_o,
    inout  wire                      OLED_SDA_io,
    output logic                     sda_in_o,
    output logic                     busy_o,
    output logic                     timeout_err_o,
    output logic [2:0]               err_ch_o
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   grant_q;
    logic [SEL_W-1:0]    sel_q;
    logic                scl_q;
    logic                sdaOe_q;
    logic                sdaOut_q;
    logic                busy_q;
    logic                timeoutErr_q;
    logic [2:0]          errCh_q;
    logic [TO_W-1:0]     wdog_q;
    logic [GAP_W-1:0]    gapCnt_q;
    logic                sdaSync1_q;
    logic                sdaSync2_q;

    logic                pickValid_d;
    logic [SEL_W-1:0]    pickSel_d;
    logic [SEL_W-1:0]    candIdx;

    logic                selDone;
    logic                selReq;
    logic                wdogExpired;
    logic                grantEnd;

`ifdef OLED_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0]    rrPtr_q;
`endif

    // Arbitration: find the channel to grant from the current request
    // vector. Both loops walk from the lowest-priority candidate up to the
    // highest, so the last hit that is written is the winner.
    always_comb begin
        pickValid_d = 1'b0;
        pickSel_d   = '0;
        candIdx     = '0;
`ifdef OLED_ARB_ROUND_ROBIN_EN
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            candIdx = SEL_W'((int'(rrPtr_q) + k) % NUM_CH);
            if (bus_io.req[candIdx]) begin
                pickValid_d = 1'b1;
                pickSel_d   = candIdx;
            end
        end
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            candIdx = SEL_W'(i);
            if (bus_io.req[candIdx]) begin
                pickValid_d = 1'b1;
                pickSel_d   = candIdx;
            end
        end
`endif
    end

    // Owner status: the termination conditions seen by the GRANT state.
    // Only the selected channel's done/req are looked at, so activity on
    // the other channels stays pending without disturbing the owner.
    assign selDone     = bus_io.done[sel_q];
    assign selReq      = bus_io.req[sel_q];
    assign wdogExpired = (wdog_q == TO_LAST);
    assign grantEnd    = selDone || !selReq || wdogExpired;

    // Main sequencer: IDLE picks a channel, GRANT forwards that channel's
    // bus values with one cycle of latency and runs the watchdog, GAP holds
    // the bus idle for GAP_CYCLES cycles. All pin and status outputs are
    // registered here so SCL and SDA share the same skew.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            sel_q        <= '0;
            scl_q        <= 1'b1;
            sdaOe_q      <= 1'b0;
            sdaOut_q     <= 1'b1;
            busy_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
            errCh_q      <= '0;
            wdog_q       <= '0;
            gapCnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    scl_q   <= 1'b1;
                    sdaOe_q <= 1'b0;
                    if (pickValid_d) begin
                        sel_q   <= pickSel_d;
                        grant_q <= NUM_CH'(1) << pickSel_d;
                        wdog_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end

                GRANT: begin
                    scl_q    <= bus_io.ch_scl[sel_q];
                    sdaOe_q  <= bus_io.ch_sda_oe[sel_q];
                    sdaOut_q <= bus_io.ch_sda_out[sel_q];
                    wdog_q   <= wdog_q + 1'b1;
                    if (grantEnd) begin
                        // A done in the same cycle as expiry is a clean
                        // finish; an abandon (req dropped) is never an error.
                        if (!selDone && wdogExpired) begin
                            timeoutErr_q <= 1'b1;
                            errCh_q      <= 3'(sel_q);
                        end
                        grant_q <= '0;
                        wdog_q  <= '0;
                        scl_q   <= 1'b1;
                        sdaOe_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            gapCnt_q <= GAP_W'(GAP_CYCLES - 1);
                            state_q  <= GAP;
                        end
                    end
                end

                GAP: begin
                    scl_q   <= 1'b1;
                    sdaOe_q <= 1'b0;
                    grant_q <= '0;
                    if (gapCnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 1'b1;
                    end
                end

                default: begin
                    grant_q <= '0;
                    scl_q   <= 1'b1;
                    sdaOe_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OLED_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: the next search starts just after the channel
    // that was most recently granted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rrPtr_q <= '0;
        end else if (state_q == IDLE && pickValid_d) begin
            rrPtr_q <= SEL_W'((int'(pickSel_d) + 1) % NUM_CH);
        end
    end
`endif

    // SDA input synchroniser: the pin is asynchronous to clk_i when a
    // slave drives an ACK, so it passes two flops before clients see it.
    // Reset to 1 to match the released (pulled-up) bus.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sdaSync1_q <= 1'b1;
            sdaSync2_q <= 1'b1;
        end else begin
            sdaSync1_q <= OLED_SDA_io;
            sdaSync2_q <= sdaSync1_q;
        end
    end

    assign bus_io.grant  = grant_q;
    assign OLED_SCL_o    = scl_q;
    assign OLED_SDA_io   = sdaOe_q ? sdaOut_q : 1'bz;
    assign sda_in_o      = sdaSync2_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = timeoutErr_q;
    assign err_ch_o      = errCh_q;

endmodule

// File: tb/tb_oled_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oled_bus_arbiter
//
// Purpose:
//   Directed testbench for oled_bus_arbiter with two channels, a 4-cycle gap
//   and a 20-cycle watchdog. Inputs change 1 time unit after a rising clock
//   edge and outputs are compared at the same point, after they have settled.
//   The released SDA line is pulled up, so "released" reads as 1.
// -----------------------------------------------------------------------------
module tb_oled_bus_arbiter;

    logic       clk;
    logic       rstN;
    wire        oledSda;
    logic       oledScl;
    logic       sdaIn;
    logic       busy;
    logic       timeoutErr;
    logic [2:0] errCh;

    int checkCount;
    int passCount;
    int failCount;

    oled_bus_arbiter_if #(.NUM_CH(2)) arbIf ();

    pullup (oledSda);

    oled_bus_arbiter #(
        .NUM_CH         (2),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (20),
        .TO_W           (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rstN),
        .bus_io        (arbIf.slave),
        .OLED_SCL_o    (oledScl),
        .OLED_SDA_io   (oledSda),
        .sda_in_o      (sdaIn),
        .busy_o        (busy),
        .timeout_err_o (timeoutErr),
        .err_ch_o      (errCh)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all client-side interface vectors at once.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] done,
                                 input logic [1:0] scl, input logic [1:0] oe,
                                 input logic [1:0] out);
        arbIf.req        = req;
        arbIf.done       = done;
        arbIf.ch_scl     = scl;
        arbIf.ch_sda_oe  = oe;
        arbIf.ch_sda_out = out;
    endtask

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bus fully idle and released, nobody granted.
    task automatic checkIdleBus(input string tag);
        checkOutput({tag, " grant"}, 8'(arbIf.grant), 8'h0);
        checkOutput({tag, " scl"},   8'(oledScl),     8'h1);
        checkOutput({tag, " sda"},   8'(oledSda),     8'h1);
        checkOutput({tag, " busy"},  8'(busy),        8'h0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rstN       = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);

        // Reset and idle
        repeat (3) tick();
        checkIdleBus("reset");
        checkOutput("reset timeout_err", 8'(timeoutErr), 8'h0);
        checkOutput("reset err_ch",      8'(errCh),      8'h0);
        checkOutput("reset sda_in",      8'(sdaIn),      8'h1);
        rstN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 25 == 0) checkIdleBus("idle");
        end
        $display("[TB] reset/idle done");

        // Single transfer on channel 1
        applyStimulus(2'b10, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("single grant",      8'(arbIf.grant), 8'h2);
        checkOutput("single busy",       8'(busy),        8'h1);
        checkOutput("single scl first",  8'(oledScl),     8'h1);
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b10, 2'b01);
        tick();
        checkOutput("single scl low",    8'(oledScl),     8'h0);
        checkOutput("single sda low",    8'(oledSda),     8'h0);
        applyStimulus(2'b10, 2'b00, 2'b11, 2'b10, 2'b01);
        tick();
        checkOutput("single scl high",   8'(oledScl),     8'h1);
        checkOutput("single sda held",   8'(oledSda),     8'h0);
        tick();
        checkOutput("single sda_in sync", 8'(sdaIn),      8'h0);
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b10, 2'b11);
        tick();
        checkOutput("single scl low2",   8'(oledScl),     8'h0);
        checkOutput("single sda high",   8'(oledSda),     8'h1);
        applyStimulus(2'b10, 2'b10, 2'b01, 2'b10, 2'b01);
        tick();
        checkOutput("single done grant", 8'(arbIf.grant), 8'h0);
        checkOutput("single gap busy",   8'(busy),        8'h1);
        checkOutput("single gap scl",    8'(oledScl),     8'h1);
        checkOutput("single gap sda",    8'(oledSda),     8'h1);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (3) tick();
        checkOutput("single gap end busy", 8'(busy),      8'h1);
        tick();
        checkOutput("single idle busy",  8'(busy),        8'h0);
        checkOutput("single timeout",    8'(timeoutErr),  8'h0);

        // Contention with fixed priority
        applyStimulus(2'b11, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("contend first",     8'(arbIf.grant), 8'h1);
        tick();
        checkOutput("contend hold",      8'(arbIf.grant), 8'h1);
        applyStimulus(2'b11, 2'b01, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("contend done0",     8'(arbIf.grant), 8'h0);
        applyStimulus(2'b10, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (4) tick();
        checkOutput("contend gap grant", 8'(arbIf.grant), 8'h0);
        checkOutput("contend gap busy",  8'(busy),        8'h0);
        tick();
        checkOutput("contend second",    8'(arbIf.grant), 8'h2);
        applyStimulus(2'b10, 2'b10, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("contend done1",     8'(arbIf.grant), 8'h0);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (4) tick();
        checkOutput("contend idle busy", 8'(busy),        8'h0);

        // Abandon: channel 1 drops req on the fifth grant cycle
        applyStimulus(2'b10, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("abandon grant",     8'(arbIf.grant), 8'h2);
        repeat (4) tick();
        checkOutput("abandon held",      8'(arbIf.grant), 8'h2);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("abandon release",   8'(arbIf.grant), 8'h0);
        checkOutput("abandon gap busy",  8'(busy),        8'h1);
        checkOutput("abandon no error",  8'(timeoutErr),  8'h0);
        repeat (4) tick();
        checkOutput("abandon idle busy", 8'(busy),        8'h0);

        // Watchdog expiry on channel 0
        applyStimulus(2'b01, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("wdog0 grant",       8'(arbIf.grant), 8'h1);
        repeat (19) tick();
        checkOutput("wdog0 still held",  8'(arbIf.grant), 8'h1);
        checkOutput("wdog0 not yet",     8'(timeoutErr),  8'h0);
        tick();
        checkOutput("wdog0 release",     8'(arbIf.grant), 8'h0);
        checkOutput("wdog0 error",       8'(timeoutErr),  8'h1);
        checkOutput("wdog0 err_ch",      8'(errCh),       8'h0);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (4) tick();

        // Watchdog expiry on channel 1
        applyStimulus(2'b10, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("wdog1 grant",       8'(arbIf.grant), 8'h2);
        repeat (19) tick();
        checkOutput("wdog1 still held",  8'(arbIf.grant), 8'h2);
        tick();
        checkOutput("wdog1 release",     8'(arbIf.grant), 8'h0);
        checkOutput("wdog1 error",       8'(timeoutErr),  8'h1);
        checkOutput("wdog1 err_ch",      8'(errCh),       8'h1);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (4) tick();

        // done and watchdog expiry together on channel 0: no new error
        applyStimulus(2'b01, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("collide grant",     8'(arbIf.grant), 8'h1);
        repeat (19) tick();
        applyStimulus(2'b01, 2'b01, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("collide release",   8'(arbIf.grant), 8'h0);
        checkOutput("collide err_ch",    8'(errCh),       8'h1);
        checkOutput("collide sticky",    8'(timeoutErr),  8'h1);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        repeat (4) tick();
        checkOutput("collide idle busy", 8'(busy),        8'h0);

        // Reset asserted mid-grant while channel 0 drives the bus low
        applyStimulus(2'b01, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        checkOutput("midrst grant",      8'(arbIf.grant), 8'h1);
        applyStimulus(2'b01, 2'b00, 2'b10, 2'b01, 2'b10);
        tick();
        checkOutput("midrst scl low",    8'(oledScl),     8'h0);
        checkOutput("midrst sda low",    8'(oledSda),     8'h0);
        rstN = 1'b0;
        #1;
        checkIdleBus("midrst async");
        checkOutput("midrst timeout_err", 8'(timeoutErr), 8'h0);
        checkOutput("midrst err_ch",     8'(errCh),       8'h0);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        rstN = 1'b1;
        tick();
        checkIdleBus("post reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
